// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO sequencer: opcodes, top FSM states, default start timeout.
// Divider states exist only when HILO_DIV_EN is defined.
package hilo_pkg;

  typedef enum logic [1:0] {
    OP_MULT = 2'd0,
    OP_DIV  = 2'd1,
    OP_MTHI = 2'd2,
    OP_MTLO = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_M_START,
    ST_M_RUN
`ifdef HILO_DIV_EN
    ,
    ST_D_START,
    ST_D_RUN
`endif
  } state_t;

  localparam int START_TIMEOUT_DEF = 4;

endpackage

// File: rtl/hilo_unit_handshake.sv
// Level-and-busy launch of one iterative unit: registered control level, start timeout
// counter, and combinational go-run / timeout / capture strobes sampled by the top FSM.
module unit_handshake
  import hilo_pkg::*;
#(
  parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_launch,
  input  logic i_in_start,
  input  logic i_in_run,
  input  logic i_unit_busy,
  output logic o_control,
  output logic o_go_run,
  output logic o_timeout,
  output logic o_capture
);

  localparam int CW = $clog2(START_TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          r_control;
  logic          w_expire;

  // The last allowed start cycle is the one whose edge still sees busy low.
  assign w_expire  = (r_cnt == CW'(START_TIMEOUT - 1));
  assign o_go_run  = i_in_start & i_unit_busy;
  assign o_timeout = i_in_start & ~i_unit_busy & w_expire;
  assign o_capture = i_in_run & ~i_unit_busy;
  assign o_control = r_control;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_control <= 1'b0;
      r_cnt     <= '0;
    end else if (i_launch) begin
      r_control <= 1'b1;
      r_cnt     <= '0;
    end else if (i_in_start) begin
      if (i_unit_busy || w_expire) begin
        r_control <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register pair and multiply/divide sequencer; capture one edge after unit busy falls,
// busy stalls the control unit and requests arriving while busy are dropped. Divider: HILO_DIV_EN.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        req_drop,
  output logic        err,
`ifdef HILO_DIV_EN
  output logic        div_control,
  input  logic        div_busy,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
`endif
  output logic        mult_control,
  input  logic        mult_busy,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo
);

  state_t      r_state;
  logic [31:0] r_hi, r_lo;
  logic        r_done, r_req_drop, r_err;
  op_t         w_op;
  logic        w_idle;
  logic        w_m_launch, w_m_go_run, w_m_timeout, w_m_capture;

  assign w_op   = op_t'(op_code);
  assign w_idle = (r_state == ST_IDLE);

  assign w_m_launch = w_idle & op_valid & (w_op == OP_MULT);

  unit_handshake #(.START_TIMEOUT(START_TIMEOUT)) u_mult_hs (
    .clk        (clk),
    .reset      (reset),
    .i_launch   (w_m_launch),
    .i_in_start (r_state == ST_M_START),
    .i_in_run   (r_state == ST_M_RUN),
    .i_unit_busy(mult_busy),
    .o_control  (mult_control),
    .o_go_run   (w_m_go_run),
    .o_timeout  (w_m_timeout),
    .o_capture  (w_m_capture)
  );

`ifdef HILO_DIV_EN
  logic w_d_launch, w_d_go_run, w_d_timeout, w_d_capture;

  assign w_d_launch = w_idle & op_valid & (w_op == OP_DIV);

  unit_handshake #(.START_TIMEOUT(START_TIMEOUT)) u_div_hs (
    .clk        (clk),
    .reset      (reset),
    .i_launch   (w_d_launch),
    .i_in_start (r_state == ST_D_START),
    .i_in_run   (r_state == ST_D_RUN),
    .i_unit_busy(div_busy),
    .o_control  (div_control),
    .o_go_run   (w_d_go_run),
    .o_timeout  (w_d_timeout),
    .o_capture  (w_d_capture)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_req_drop <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_req_drop <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (op_valid) begin
            case (w_op)
              OP_MULT: r_state <= ST_M_START;
`ifdef HILO_DIV_EN
              OP_DIV:  r_state <= ST_D_START;
`endif
              OP_MTHI: r_hi <= wdata;
              OP_MTLO: r_lo <= wdata;
              default: r_req_drop <= 1'b1;
            endcase
          end
        end
        ST_M_START: begin
          r_req_drop <= op_valid;
          if (w_m_go_run) begin
            r_state <= ST_M_RUN;
          end else if (w_m_timeout) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b1;
          end
        end
        ST_M_RUN: begin
          r_req_drop <= op_valid;
          if (w_m_capture) begin
            r_hi    <= mult_hi;
            r_lo    <= mult_lo;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
`ifdef HILO_DIV_EN
        ST_D_START: begin
          r_req_drop <= op_valid;
          if (w_d_go_run) begin
            r_state <= ST_D_RUN;
          end else if (w_d_timeout) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b1;
          end
        end
        ST_D_RUN: begin
          r_req_drop <= op_valid;
          if (w_d_capture) begin
            r_hi    <= div_hi;
            r_lo    <= div_lo;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = ~w_idle;
  assign done     = r_done;
  assign req_drop = r_req_drop;
  assign err      = r_err;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: MTHI/MTLO vector table, then multiply, drop, reset-abort,
// start-timeout and divide sequences against behavioural unit models.
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'd0;
  logic [31:0] wdata = '0;
  logic [31:0] hi, lo, mult_hi, mult_lo;
  logic        busy, done, req_drop, err, mult_control;
  logic        mult_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Multiplier model: busy rises on the first edge seeing control, falls 32 edges later.
  logic        m_en = 1'b1;
  logic [31:0] m_x = '0, m_y = '0;
  logic [5:0]  m_cnt;
  logic [63:0] m_prod;
  assign m_prod  = {{32{m_x[31]}}, m_x} * {{32{m_y[31]}}, m_y};
  assign mult_hi = mult_busy ? 32'hBAD0BAD0 : m_prod[63:32];
  assign mult_lo = mult_busy ? 32'hBAD1BAD1 : m_prod[31:0];

  always @(posedge clk) begin
    if (reset) begin
      mult_busy <= 1'b0;
      m_cnt     <= '0;
    end else if (!mult_busy) begin
      if (mult_control && m_en) begin
        mult_busy <= 1'b1;
        m_cnt     <= '0;
      end
    end else begin
      if (m_cnt == 6'd31) mult_busy <= 1'b0;
      m_cnt <= m_cnt + 6'd1;
    end
  end

`ifdef HILO_DIV_EN
  logic        div_control, div_busy;
  logic [31:0] div_hi, div_lo;
  logic [2:0]  d_cnt;
  assign div_hi = div_busy ? 32'hBAD2BAD2 : 32'd1;
  assign div_lo = div_busy ? 32'hBAD3BAD3 : 32'd3;

  always @(posedge clk) begin
    if (reset) begin
      div_busy <= 1'b0;
      d_cnt    <= '0;
    end else if (!div_busy) begin
      if (div_control) begin
        div_busy <= 1'b1;
        d_cnt    <= '0;
      end
    end else begin
      if (d_cnt == 3'd4) div_busy <= 1'b0;
      d_cnt <= d_cnt + 3'd1;
    end
  end
`endif

  hilo_unit dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .wdata       (wdata),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .req_drop    (req_drop),
    .err         (err),
`ifdef HILO_DIV_EN
    .div_control (div_control),
    .div_busy    (div_busy),
    .div_hi      (div_hi),
    .div_lo      (div_lo),
`endif
    .mult_control(mult_control),
    .mult_busy   (mult_busy),
    .mult_hi     (mult_hi),
    .mult_lo     (mult_lo)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  // Advance one edge and settle outputs; inputs are then changed away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] code, input logic [31:0] wd);
    op_valid = 1'b1;
    op_code  = code;
    wdata    = wd;
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  code;
    logic [31:0] wd;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t tbl[6];
  int   n_done;
  logic saw_done;

  initial begin
    tbl[0] = '{1'b1, 2'd2, 32'h12345678, 32'h12345678, 32'h00000000};
    tbl[1] = '{1'b1, 2'd3, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0};
    tbl[2] = '{1'b0, 2'd2, 32'h55555555, 32'h12345678, 32'h9ABCDEF0};
    tbl[3] = '{1'b1, 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h9ABCDEF0};
    tbl[4] = '{1'b1, 2'd3, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
    tbl[5] = '{1'b0, 2'd3, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h00000000};

    // Reset state, with op_valid asserted to show reset wins.
    issue(2'd2, 32'hCAFECAFE);
    step();
    step();
    chk32("rst_hi", hi, 32'h0);
    chk32("rst_lo", lo, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_drop", req_drop, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_mctl", mult_control, 1'b0);
    op_valid = 1'b0;
    reset    = 1'b0;

    // MTHI/MTLO table: new value visible right after the accepting edge.
    for (int i = 0; i < 6; i++) begin
      op_valid = tbl[i].v;
      op_code  = tbl[i].code;
      wdata    = tbl[i].wd;
      step();
      chk32("tbl_hi", hi, tbl[i].ehi);
      chk32("tbl_lo", lo, tbl[i].elo);
      chk1("tbl_busy", busy, 1'b0);
      chk1("tbl_done", done, 1'b0);
      chk1("tbl_drop", req_drop, 1'b0);
    end
    op_valid = 1'b0;

    // MULT 3 * -2, then MTLO accepted in the done cycle.
    m_x = 32'd3;
    m_y = 32'hFFFFFFFE;
    issue(2'd0, 32'h0);
    step();
    op_valid = 1'b0;
    chk1("mul_e0_busy", busy, 1'b1);
    chk1("mul_e0_ctl", mult_control, 1'b1);
    n_done = 0;
    for (int k = 1; k <= 34; k++) begin
      step();
      if (k == 1) chk1("mul_e1_ctl", mult_control, 1'b1);
      if (k == 2) chk1("mul_e2_ctl", mult_control, 1'b0);
      if (k < 34) begin
        chk1("mul_busy_win", busy, 1'b1);
        if (done) n_done++;
      end else begin
        chk1("mul_done", done, 1'b1);
        chk1("mul_busy_end", busy, 1'b0);
        chk32("mul_hi", hi, 32'hFFFFFFFF);
        chk32("mul_lo", lo, 32'hFFFFFFFA);
      end
    end
    chk32("mul_early_done", n_done, 0);
    issue(2'd3, 32'hAAAA5555);
    step();
    op_valid = 1'b0;
    chk1("b2b_done_low", done, 1'b0);
    chk1("b2b_busy", busy, 1'b0);
    chk32("b2b_lo", lo, 32'hAAAA5555);
    chk32("b2b_hi", hi, 32'hFFFFFFFF);

    // Request during MULT is dropped and leaves HI untouched.
    issue(2'd0, 32'h0);
    step();
    op_valid = 1'b0;
    saw_done = 1'b0;
    for (int k = 1; k <= 40 && !saw_done; k++) begin
      if (k == 10) issue(2'd2, 32'hDEADBEEF);
      step();
      op_valid = 1'b0;
      if (k == 10) chk1("drop_pulse", req_drop, 1'b1);
      if (k == 11) chk1("drop_end", req_drop, 1'b0);
      if (done) saw_done = 1'b1;
    end
    chk1("drop_mul_done", saw_done, 1'b1);
    chk32("drop_hi", hi, 32'hFFFFFFFF);
    chk32("drop_lo", lo, 32'hFFFFFFFA);

    // Reset at E10 of a MULT aborts with no later done.
    issue(2'd0, 32'h0);
    step();
    op_valid = 1'b0;
    for (int k = 1; k <= 9; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk32("rstmid_hi", hi, 32'h0);
    chk32("rstmid_lo", lo, 32'h0);
    chk1("rstmid_busy", busy, 1'b0);
    chk1("rstmid_ctl", mult_control, 1'b0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done) n_done++;
    end
    chk32("rstmid_no_done", n_done, 0);

    // Start timeout: multiplier never answers.
    issue(2'd2, 32'h11111111);
    step();
    issue(2'd3, 32'h22222222);
    step();
    m_en = 1'b0;
    issue(2'd0, 32'h0);
    step();
    op_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k < 4) begin
        chk1("to_err_early", err, 1'b0);
        chk1("to_busy", busy, 1'b1);
        chk1("to_ctl", mult_control, 1'b1);
      end else begin
        chk1("to_err", err, 1'b1);
        chk1("to_ctl_low", mult_control, 1'b0);
        chk1("to_idle", busy, 1'b0);
        chk1("to_no_done", done, 1'b0);
        chk32("to_hi", hi, 32'h11111111);
        chk32("to_lo", lo, 32'h22222222);
      end
    end
    step();
    chk1("to_err_end", err, 1'b0);
    m_en = 1'b1;

`ifdef HILO_DIV_EN
    issue(2'd1, 32'h0);
    step();
    op_valid = 1'b0;
    chk1("div_busy", busy, 1'b1);
    saw_done = 1'b0;
    for (int k = 1; k <= 20 && !saw_done; k++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    chk1("div_done", saw_done, 1'b1);
    chk32("div_hi", hi, 32'h1);
    chk32("div_lo", lo, 32'h3);
`else
    issue(2'd1, 32'h0);
    step();
    op_valid = 1'b0;
    chk1("div_drop", req_drop, 1'b1);
    chk1("div_busy", busy, 1'b0);
    chk32("div_hi", hi, 32'h11111111);
    chk32("div_lo", lo, 32'h22222222);
    step();
    chk1("div_drop_end", req_drop, 1'b0);
    chk1("div_busy_end", busy, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
